// File: rtl/input_filter_bank.sv
// Multi-channel pushbutton/switch conditioner: 2-flop synchroniser, tick-sampled
// debounce, and registered rise/fall/long-press one-shots per channel.
module input_filter_bank #(
   parameter int unsigned CHANNELS     = 4,
   parameter int unsigned TICK_DIV     = 250000,
   parameter int unsigned STABLE_TICKS = 4,
   parameter int unsigned HOLD_TICKS   = 400
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] raw_in,
   output logic [CHANNELS-1:0] level_out,
   output logic [CHANNELS-1:0] rise_pulse,
   output logic [CHANNELS-1:0] fall_pulse,
   output logic [CHANNELS-1:0] hold_pulse,
   output logic                tick_out
);

   localparam int unsigned TW = $clog2(TICK_DIV);
   localparam int unsigned SW = $clog2(STABLE_TICKS) + 1;
   localparam int unsigned HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

   localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
   localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_TICKS - 1);
   localparam logic [HW-1:0] HOLD_MAX    = HW'(HOLD_TICKS);

   logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
   logic                tick;
   logic [CHANNELS-1:0] meta_q, sync_q;
   logic [CHANNELS-1:0] level_q, level_d;
   logic [CHANNELS-1:0] rise_q, rise_d;
   logic [CHANNELS-1:0] fall_q, fall_d;
   logic [CHANNELS-1:0] hold_q, hold_d;
   logic [SW-1:0]       stable_q  [CHANNELS];
   logic [SW-1:0]       stable_d  [CHANNELS];
   logic [HW-1:0]       holdcnt_q [CHANNELS];
   logic [HW-1:0]       holdcnt_d [CHANNELS];

   assign tick = (tick_cnt_q == TICK_LAST);

   always_comb begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
      level_d    = level_q;
      rise_d     = '0;
      fall_d     = '0;
      hold_d     = '0;
      stable_d   = stable_q;
      holdcnt_d  = holdcnt_q;
      if (tick) begin
         for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (sync_q[c] == level_q[c]) begin
               stable_d[c] = '0;
            end else if (stable_q[c] == STABLE_LAST) begin
               level_d[c]  = sync_q[c];
               stable_d[c] = '0;
               rise_d[c]   = sync_q[c];
               fall_d[c]   = ~sync_q[c];
            end else begin
               stable_d[c] = stable_q[c] + 1'b1;
            end
            // A falling decision clears hold progress even if it would have hit HOLD_MAX.
            if (level_q[c] && !level_d[c]) begin
               holdcnt_d[c] = '0;
            end else if (level_q[c] && (holdcnt_q[c] != HOLD_MAX)) begin
               holdcnt_d[c] = holdcnt_q[c] + 1'b1;
               hold_d[c]    = (holdcnt_q[c] + 1'b1 == HOLD_MAX);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt_q <= '0;
         meta_q     <= '0;
         sync_q     <= '0;
         level_q    <= '0;
         rise_q     <= '0;
         fall_q     <= '0;
         hold_q     <= '0;
         stable_q   <= '{default: '0};
         holdcnt_q  <= '{default: '0};
      end else begin
         tick_cnt_q <= tick_cnt_d;
         meta_q     <= raw_in;
         sync_q     <= meta_q;
         level_q    <= level_d;
         rise_q     <= rise_d;
         fall_q     <= fall_d;
         hold_q     <= hold_d;
         stable_q   <= stable_d;
         holdcnt_q  <= holdcnt_d;
      end
   end

   assign level_out  = level_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;
   assign hold_pulse = hold_q;
   assign tick_out   = tick;

endmodule
